// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// The response struct is the unit carried through the latency pipeline.
package imem_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            err;
    logic [XLEN-1:0] rdata;
  } imem_resp_t;

  // Word offset of addr from base; the byte lane bits are dropped.
  function automatic logic [XLEN-3:0] word_index(input logic [XLEN-1:0] addr,
                                                 input logic [XLEN-1:0] base);
    logic [XLEN-1:0] off;
    off = addr - base;
    return off[XLEN-1:2];
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-latency shift register of responses; no backpressure, async clear.
// The last stage drives the responder outputs directly.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [$bits(imem_resp_t)-1:0]  in_i,
  output logic [$bits(imem_resp_t)-1:0]  out_o
);

  imem_resp_t stage_q [LATENCY];
  imem_resp_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = imem_resp_t'(in_i);
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: combinational grant, in-order responses after
// a fixed latency, bounded outstanding count, and a preload write port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        gnt_stall_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic [2:0]  outstanding_o
);

  localparam int              AW       = $clog2(MEM_WORDS);
  localparam logic [XLEN-1:0] SPAN     = XLEN'(4 * MEM_WORDS);
  localparam logic [2:0]      MAX_OUT  = 3'(MAX_OUTSTANDING);
  localparam logic [XLEN:0]   END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  localparam bit CFG_OK = (MEM_WORDS >= 2) && ((MEM_WORDS & (MEM_WORDS - 1)) == 0)
                       && (LATENCY >= 1) && (LATENCY <= 4)
                       && (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= LATENCY + 1)
                       && (END_ADDR <= 33'h1_0000_0000)
                       && ((BASE_ADDR & (SPAN - 32'd1)) == 32'd0);

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic [2:0]      outstanding_q, outstanding_d;
  logic            accept;
  logic [XLEN-3:0] rd_word, ld_word;
  logic            rd_in_range, ld_in_range;
  logic [AW-1:0]   rd_idx, ld_idx;
  imem_resp_t      resp_in, resp_out;

  // In range iff the word offset has no bits above the index field, which is
  // the unsigned (addr - BASE_ADDR) < 4*MEM_WORDS test for a power-of-two store.
  always_comb begin
    rd_word     = word_index(instr_addr_i, BASE_ADDR);
    ld_word     = word_index(load_addr_i, BASE_ADDR);
    rd_in_range = ~|rd_word[XLEN-3:AW];
    ld_in_range = ~|ld_word[XLEN-3:AW];
    rd_idx      = rd_word[AW-1:0];
    ld_idx      = ld_word[AW-1:0];
  end

  // A retiring response frees its slot in the same cycle it is presented.
  assign instr_gnt_o = rstn & instr_req_i & ~gnt_stall_i
                     & ((outstanding_q < MAX_OUT) | resp_out.valid);
  assign accept      = instr_req_i & instr_gnt_o;

  always_comb begin
    resp_in = '0;
    if (accept) begin
      resp_in.valid = 1'b1;
      resp_in.err   = ~rd_in_range;
      resp_in.rdata = rd_in_range ? mem[rd_idx] : '0;
    end
  end

  // Store is not reset; a same-edge read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (load_we_i && ld_in_range) begin
      mem[ld_idx] <= load_wdata_i;
    end
  end

  imem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk   (clk),
    .rstn  (rstn),
    .in_i  (resp_in),
    .out_o (resp_out)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !resp_out.valid) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!accept && resp_out.valid) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign instr_rvalid_o = resp_out.valid;
  assign instr_err_o    = resp_out.err;
  assign instr_rdata_o  = resp_out.rdata;
  assign outstanding_o  = outstanding_q;

  a_cfg_ok: assert property (@(posedge clk) CFG_OK);
  a_max_outstanding: assert property (@(posedge clk) disable iff (!rstn)
    outstanding_q <= MAX_OUT);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(resp_out.valid && (outstanding_q == 3'd0)));

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: four responders (LATENCY 1..4) share one stimulus stream,
// each scenario task checks the instance whose configuration it targets.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        stall = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_wdata = '0;

  logic [3:0]  gnt_w, rvalid_w, err_w;
  logic [31:0] rdata_w [4];
  logic [2:0]  outs_w [4];

  int total = 0;
  int bad = 0;

  logic [31:0] prog [6];

  always #5 clk = ~clk;

  // Instance gi has LATENCY gi+1; instance 2 has MAX_OUTSTANDING 1, instance 3 has 4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    imem_responder #(
      .MEM_WORDS       (1024),
      .BASE_ADDR       (32'h0000_0000),
      .LATENCY         (gi + 1),
      .MAX_OUTSTANDING ((gi == 2) ? 1 : ((gi == 3) ? 4 : 2))
    ) u_dut (
      .clk            (clk),
      .rstn           (rstn),
      .instr_req_i    (req),
      .instr_addr_i   (addr),
      .instr_gnt_o    (gnt_w[gi]),
      .instr_rvalid_o (rvalid_w[gi]),
      .instr_rdata_o  (rdata_w[gi]),
      .instr_err_o    (err_w[gi]),
      .gnt_stall_i    (stall),
      .load_we_i      (load_we),
      .load_addr_i    (load_addr),
      .load_wdata_i   (load_wdata),
      .outstanding_o  (outs_w[gi])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 1'b1;
    addr = 32'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if (gnt_w[i] !== 1'b0) begin bad++; $display("FAIL reset_gnt[%0d]: got %b want 0", i, gnt_w[i]); end
      total++; if (rvalid_w[i] !== 1'b0) begin bad++; $display("FAIL reset_rvalid[%0d]: got %b want 0", i, rvalid_w[i]); end
      total++; if (rdata_w[i] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", i, rdata_w[i]); end
      total++; if (err_w[i] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", i, err_w[i]); end
      total++; if (outs_w[i] !== 3'd0) begin bad++; $display("FAIL reset_outstanding[%0d]: got %0d want 0", i, outs_w[i]); end
    end
    req = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic preload();
    prog[0] = 32'h00000013; prog[1] = 32'h00100093; prog[2] = 32'h00200113;
    prog[3] = 32'h00300193; prog[4] = 32'h00400213; prog[5] = 32'h00500293;
    load_we = 1'b1;
    for (int k = 0; k < 6; k++) begin
      load_addr = 32'(k * 4);
      load_wdata = prog[k];
      step();
    end
    load_we = 1'b0;
    $display("preload: 6 words written");
  endtask

  task automatic test_single();
    req = 1'b1;
    addr = 32'h0;
    @(negedge clk);
    total++; if (gnt_w[0] !== 1'b1) begin bad++; $display("FAIL single_gnt: got %b want 1", gnt_w[0]); end
    step();
    req = 1'b0;
    @(negedge clk);
    total++; if (rvalid_w[0] !== 1'b1) begin bad++; $display("FAIL single_rvalid: got %b want 1", rvalid_w[0]); end
    total++; if (rdata_w[0] !== 32'h00000013) begin bad++; $display("FAIL single_rdata: got %h want 00000013", rdata_w[0]); end
    total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err_w[0]); end
    total++; if (rvalid_w[1] !== 1'b0) begin bad++; $display("FAIL single_lat2_early: got %b want 0", rvalid_w[1]); end
    step();
    repeat (5) step();
    $display("test_single: done");
  endtask

  task automatic test_back_to_back();
    int ngnt = 0, nresp = 0, last_gnt_c = -1, first_resp_c = -1, last_resp_c = -1;
    logic g;
    req = 1'b1;
    addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      g = gnt_w[1];
      if (g) last_gnt_c = c;
      if (rvalid_w[1]) begin
        total++; if (rdata_w[1] !== prog[nresp]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", nresp, rdata_w[1], prog[nresp]); end
        if (first_resp_c < 0) first_resp_c = c;
        last_resp_c = c;
        nresp++;
      end
      total++; if (outs_w[1] > 3'd2) begin bad++; $display("FAIL b2b_outstanding: got %0d want <=2", outs_w[1]); end
      step();
      if (g && req) begin
        ngnt++;
        addr = 32'(ngnt * 4);
        if (ngnt == 4) req = 1'b0;
      end
    end
    total++; if (last_gnt_c !== 3) begin bad++; $display("FAIL b2b_gnt_run: got last grant cycle %0d want 3", last_gnt_c); end
    total++; if (nresp !== 4) begin bad++; $display("FAIL b2b_nresp: got %0d want 4", nresp); end
    total++; if (first_resp_c !== 2) begin bad++; $display("FAIL b2b_first_resp: got cycle %0d want 2", first_resp_c); end
    total++; if (last_resp_c !== 5) begin bad++; $display("FAIL b2b_last_resp: got cycle %0d want 5", last_resp_c); end
    $display("test_back_to_back: %0d grants, %0d responses", ngnt, nresp);
  endtask

  task automatic test_max1();
    req = 1'b1;
    addr = 32'h4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (gnt_w[2] !== ((c % 3) == 0)) begin bad++; $display("FAIL max1_gnt c%0d: got %b want %b", c, gnt_w[2], (c % 3) == 0); end
      total++; if (outs_w[2] !== ((c == 0) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL max1_outstanding c%0d: got %0d want %0d", c, outs_w[2], (c == 0) ? 0 : 1); end
      total++; if (rvalid_w[2] !== (c >= 3 && (c % 3) == 0)) begin bad++; $display("FAIL max1_rvalid c%0d: got %b want %b", c, rvalid_w[2], c >= 3 && (c % 3) == 0); end
      if (rvalid_w[2]) begin
        total++; if (rdata_w[2] !== 32'h00100093) begin bad++; $display("FAIL max1_rdata c%0d: got %h want 00100093", c, rdata_w[2]); end
      end
      step();
    end
    req = 1'b0;
    repeat (6) step();
    $display("test_max1: done");
  endtask

  task automatic test_out_of_range();
    logic [31:0] t_addr [4];
    logic        t_err  [4];
    logic [31:0] t_data [4];
    // An out-of-range preload that would alias onto word 0 must be dropped.
    load_we = 1'b1;
    load_addr = 32'h0000_1000;
    load_wdata = 32'hFFFF_FFFF;
    step();
    load_we = 1'b0;
    t_addr[0] = 32'h0000_1000; t_err[0] = 1'b1; t_data[0] = 32'h0;
    t_addr[1] = 32'h0000_0000; t_err[1] = 1'b0; t_data[1] = 32'h00000013;
    t_addr[2] = 32'h0000_0006; t_err[2] = 1'b0; t_data[2] = 32'h00100093;
    t_addr[3] = 32'hFFFF_FFFC; t_err[3] = 1'b1; t_data[3] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      req = 1'b1;
      addr = t_addr[k];
      @(negedge clk);
      total++; if (gnt_w[0] !== 1'b1) begin bad++; $display("FAIL oor_gnt %h: got %b want 1", t_addr[k], gnt_w[0]); end
      step();
      req = 1'b0;
      @(negedge clk);
      total++; if (rvalid_w[0] !== 1'b1) begin bad++; $display("FAIL oor_rvalid %h: got %b want 1", t_addr[k], rvalid_w[0]); end
      total++; if (err_w[0] !== t_err[k]) begin bad++; $display("FAIL oor_err %h: got %b want %b", t_addr[k], err_w[0], t_err[k]); end
      total++; if (rdata_w[0] !== t_data[k]) begin bad++; $display("FAIL oor_rdata %h: got %h want %h", t_addr[k], rdata_w[0], t_data[k]); end
      step();
      $display("test_out_of_range: addr %h err %b rdata %h", t_addr[k], err_w[0], rdata_w[0]);
    end
    repeat (5) step();
  endtask

  task automatic test_stall();
    req = 1'b1;
    addr = 32'h8;
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (gnt_w[0] !== 1'b0) begin bad++; $display("FAIL stall_gnt c%0d: got %b want 0", c, gnt_w[0]); end
      total++; if (rvalid_w[0] !== 1'b0) begin bad++; $display("FAIL stall_rvalid c%0d: got %b want 0", c, rvalid_w[0]); end
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if (gnt_w[0] !== 1'b1) begin bad++; $display("FAIL stall_release_gnt: got %b want 1", gnt_w[0]); end
    step();
    req = 1'b0;
    @(negedge clk);
    total++; if (rvalid_w[0] !== 1'b1) begin bad++; $display("FAIL stall_rvalid_after: got %b want 1", rvalid_w[0]); end
    total++; if (rdata_w[0] !== 32'h00200113) begin bad++; $display("FAIL stall_rdata: got %h want 00200113", rdata_w[0]); end
    step();
    repeat (5) step();
    $display("test_stall: done");
  endtask

  task automatic test_reset_midop();
    req = 1'b1;
    addr = 32'h0;
    @(negedge clk);
    total++; if (gnt_w[3] !== 1'b1) begin bad++; $display("FAIL midrst_gnt0: got %b want 1", gnt_w[3]); end
    step();
    addr = 32'h4;
    @(negedge clk);
    total++; if (gnt_w[3] !== 1'b1) begin bad++; $display("FAIL midrst_gnt1: got %b want 1", gnt_w[3]); end
    step();
    req = 1'b0;
    @(negedge clk);
    total++; if (outs_w[3] !== 3'd2) begin bad++; $display("FAIL midrst_outstanding_pre: got %0d want 2", outs_w[3]); end
    rstn = 1'b0;
    step();
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (rvalid_w[3] !== 1'b0) begin bad++; $display("FAIL midrst_rvalid c%0d: got %b want 0", c, rvalid_w[3]); end
      total++; if (outs_w[3] !== 3'd0) begin bad++; $display("FAIL midrst_outstanding c%0d: got %0d want 0", c, outs_w[3]); end
      step();
    end
    // Write and read word 5 in the same cycle: the read sees the old word.
    load_we = 1'b1;
    load_addr = 32'h14;
    load_wdata = 32'hDEADBEEF;
    req = 1'b1;
    addr = 32'h14;
    @(negedge clk);
    total++; if (gnt_w[0] !== 1'b1) begin bad++; $display("FAIL rw_gnt: got %b want 1", gnt_w[0]); end
    step();
    load_we = 1'b0;
    @(negedge clk);
    total++; if (rvalid_w[0] !== 1'b1) begin bad++; $display("FAIL rw_old_rvalid: got %b want 1", rvalid_w[0]); end
    total++; if (rdata_w[0] !== 32'h00500293) begin bad++; $display("FAIL rw_old_rdata: got %h want 00500293", rdata_w[0]); end
    step();
    req = 1'b0;
    @(negedge clk);
    total++; if (rdata_w[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_new_rdata: got %h want deadbeef", rdata_w[0]); end
    step();
    $display("test_reset_midop: done");
  endtask

  initial begin
    test_reset();
    preload();
    test_single();
    test_back_to_back();
    test_max1();
    test_out_of_range();
    test_stall();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
